// File: rtl/rx_link_ctrl.sv
// Receive-side link sequencer for the 10G 64b/66b path: lock/realign/stabilize/BER supervision.
// Define RX_LINK_STATS_EN to build the err/drop statistics counters; otherwise they read zero.
module rx_link_ctrl #(
    parameter int unsigned P_LOCK_TIMEOUT = 4096,
    parameter int unsigned P_REALIGN_LEN  = 4,
    parameter int unsigned P_STABLE_CNT   = 64,
    parameter int unsigned P_BER_WINDOW   = 1024,
    parameter int unsigned P_BER_THRESH   = 16,
    parameter int unsigned P_HIBER_LIMIT  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  head_i,
    input  logic        head_valid_i,
    input  logic        locked_i,
    input  logic        decode_error_i,
    input  logic        clr_stats_i,
    output logic        realign_o,
    output logic        dp_rst_o,
    output logic        link_up_o,
    output logic        hi_ber_o,
    output logic [2:0]  state_o,
    output logic [15:0] err_cnt_o,
    output logic [15:0] drop_cnt_o
);

    localparam logic [2:0] S_RESET     = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_REALIGN   = 3'd2;
    localparam logic [2:0] S_STABILIZE = 3'd3;
    localparam logic [2:0] S_LINK_UP   = 3'd4;
    localparam logic [2:0] S_HI_BER    = 3'd5;

    localparam int unsigned TMO_W = $clog2(P_LOCK_TIMEOUT + 1);
    localparam int unsigned RL_W  = $clog2(P_REALIGN_LEN + 1);
    localparam int unsigned STB_W = $clog2(P_STABLE_CNT + 1);
    localparam int unsigned WIN_W = $clog2(P_BER_WINDOW + 1);
    localparam int unsigned BAD_W = $clog2(P_BER_THRESH + 1);
    localparam int unsigned HIB_W = $clog2(P_HIBER_LIMIT + 1);

    logic [2:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [RL_W-1:0]  rl_cnt_q, rl_cnt_d;
    logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [BAD_W-1:0] bad_cnt_q, bad_cnt_d;
    logic [HIB_W-1:0] hib_cnt_q, hib_cnt_d;

    logic             realign_q, dp_rst_q, link_up_q, hi_ber_q;

    logic             good, bad;
    logic [BAD_W:0]   bad_sum;
    logic             ber_hit;
    logic             win_last;

    assign good = head_valid_i & (head_i == 2'b01 | head_i == 2'b10) & ~decode_error_i;
    assign bad  = head_valid_i & (head_i == 2'b00 | head_i == 2'b11);

    // The current header is included, so the threshold can trip on the very header that reaches it.
    assign bad_sum  = {1'b0, bad_cnt_q} + {{BAD_W{1'b0}}, bad};
    assign ber_hit  = bad_sum >= (BAD_W + 1)'(P_BER_THRESH);
    assign win_last = head_valid_i & (win_cnt_q == WIN_W'(P_BER_WINDOW - 1));

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        rl_cnt_d  = rl_cnt_q;
        stb_cnt_d = stb_cnt_q;
        win_cnt_d = win_cnt_q;
        bad_cnt_d = bad_cnt_q;
        hib_cnt_d = hib_cnt_q;

        case (state_q)
            S_RESET: begin
                state_d = S_WAIT_LOCK;
            end

            S_WAIT_LOCK: begin
                if (locked_i) begin
                    state_d = S_STABILIZE;
                end else if (tmo_cnt_q == TMO_W'(P_LOCK_TIMEOUT - 1)) begin
                    state_d = S_REALIGN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            S_REALIGN: begin
                if (rl_cnt_q == RL_W'(P_REALIGN_LEN - 1)) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    rl_cnt_d = rl_cnt_q + RL_W'(1);
                end
            end

            S_STABILIZE: begin
                if (!locked_i) begin
                    state_d = S_WAIT_LOCK;
                end else if (bad || decode_error_i) begin
                    stb_cnt_d = '0;
                end else if (good) begin
                    if (stb_cnt_q == STB_W'(P_STABLE_CNT - 1)) begin
                        state_d = S_LINK_UP;
                    end else begin
                        stb_cnt_d = stb_cnt_q + STB_W'(1);
                    end
                end
            end

            S_LINK_UP: begin
                if (!locked_i) begin
                    state_d = S_REALIGN;
                end else if (ber_hit) begin
                    state_d = S_HI_BER;
                end else if (win_last) begin
                    win_cnt_d = '0;
                    bad_cnt_d = '0;
                end else if (head_valid_i) begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                    bad_cnt_d = bad_sum[BAD_W-1:0];
                end
            end

            S_HI_BER: begin
                if (!locked_i) begin
                    state_d = S_REALIGN;
                end else if (ber_hit) begin
                    // A window that reaches the threshold restarts at once and counts toward the limit.
                    win_cnt_d = '0;
                    bad_cnt_d = '0;
                    if (hib_cnt_q == HIB_W'(P_HIBER_LIMIT - 1)) begin
                        state_d = S_REALIGN;
                    end else begin
                        hib_cnt_d = hib_cnt_q + HIB_W'(1);
                    end
                end else if (win_last) begin
                    state_d = S_LINK_UP;
                end else if (head_valid_i) begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                    bad_cnt_d = bad_sum[BAD_W-1:0];
                end
            end

            default: begin
                state_d = S_RESET;
            end
        endcase

        if (state_d != state_q) begin
            tmo_cnt_d = '0;
            rl_cnt_d  = '0;
            stb_cnt_d = '0;
            win_cnt_d = '0;
            bad_cnt_d = '0;
            hib_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_RESET;
            tmo_cnt_q <= '0;
            rl_cnt_q  <= '0;
            stb_cnt_q <= '0;
            win_cnt_q <= '0;
            bad_cnt_q <= '0;
            hib_cnt_q <= '0;
            realign_q <= 1'b0;
            dp_rst_q  <= 1'b1;
            link_up_q <= 1'b0;
            hi_ber_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            rl_cnt_q  <= rl_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            win_cnt_q <= win_cnt_d;
            bad_cnt_q <= bad_cnt_d;
            hib_cnt_q <= hib_cnt_d;
            // Status flops are loaded from the next state so they change together with state_q.
            realign_q <= (state_d == S_REALIGN);
            dp_rst_q  <= (state_d == S_RESET) | (state_d == S_WAIT_LOCK) | (state_d == S_REALIGN);
            link_up_q <= (state_d == S_LINK_UP);
            hi_ber_q  <= (state_d == S_HI_BER);
        end
    end

    assign realign_o = realign_q;
    assign dp_rst_o  = dp_rst_q;
    assign link_up_o = link_up_q;
    assign hi_ber_o  = hi_ber_q;
    assign state_o   = state_q;

`ifdef RX_LINK_STATS_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] err_sum;
    logic        link_exit;

    assign err_sum   = {1'b0, err_cnt_q} + {16'd0, bad} + {16'd0, decode_error_i};
    assign link_exit = (state_q == S_LINK_UP) && (state_d != S_LINK_UP);

    always_comb begin
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_stats_i) begin
            err_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (link_exit && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`else
    logic unused_clr_stats;
    assign unused_clr_stats = clr_stats_i;
    assign err_cnt_o        = '0;
    assign drop_cnt_o       = '0;
`endif

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Self-checking bench for rx_link_ctrl: directed scenarios plus biased random traffic against a reference model.
module tb_rx_link_ctrl;

    localparam int unsigned LOCK_TMO = 4096;
    localparam int unsigned RL_LEN   = 4;
    localparam int unsigned STABLE   = 64;
    localparam int unsigned WIN      = 1024;
    localparam int unsigned THRESH   = 16;
    localparam int unsigned HIB_LIM  = 8;

    localparam int ST_RESET = 0, ST_WAIT = 1, ST_REALIGN = 2, ST_STAB = 3, ST_UP = 4, ST_HIBER = 5;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  head_i;
    logic        head_valid_i;
    logic        locked_i;
    logic        decode_error_i;
    logic        clr_stats_i;
    logic        realign_o;
    logic        dp_rst_o;
    logic        link_up_o;
    logic        hi_ber_o;
    logic [2:0]  state_o;
    logic [15:0] err_cnt_o;
    logic [15:0] drop_cnt_o;

    always #5 clk_i = ~clk_i;

    rx_link_ctrl #(
        .P_LOCK_TIMEOUT(LOCK_TMO),
        .P_REALIGN_LEN (RL_LEN),
        .P_STABLE_CNT  (STABLE),
        .P_BER_WINDOW  (WIN),
        .P_BER_THRESH  (THRESH),
        .P_HIBER_LIMIT (HIB_LIM)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .head_i        (head_i),
        .head_valid_i  (head_valid_i),
        .locked_i      (locked_i),
        .decode_error_i(decode_error_i),
        .clr_stats_i   (clr_stats_i),
        .realign_o     (realign_o),
        .dp_rst_o      (dp_rst_o),
        .link_up_o     (link_up_o),
        .hi_ber_o      (hi_ber_o),
        .state_o       (state_o),
        .err_cnt_o     (err_cnt_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: link mode plus the elapsed/observed quantities the rules talk about.
    int m_mode;
    int m_waited;      // cycles spent waiting for lock
    int m_pulse;       // realign cycles already issued
    int m_run;         // run of good headers while stabilizing
    int m_seen;        // valid headers in current BER window
    int m_errs;        // bad headers in current BER window
    int m_bad_wins;    // consecutive threshold windows while in hi-BER
    int m_err;
    int m_drop;

    task automatic model_step();
        int good, bad, de, nxt;
        de   = int'(decode_error_i);
        good = (head_valid_i && (head_i == 2'b01 || head_i == 2'b10) && !decode_error_i) ? 1 : 0;
        bad  = (head_valid_i && (head_i == 2'b00 || head_i == 2'b11)) ? 1 : 0;
        if (rst_i) begin
            m_mode = ST_RESET; m_waited = 0; m_pulse = 0; m_run = 0;
            m_seen = 0; m_errs = 0; m_bad_wins = 0; m_err = 0; m_drop = 0;
            return;
        end
        nxt = m_mode;
        if (m_mode == ST_RESET) begin
            nxt = ST_WAIT;
        end else if (m_mode == ST_WAIT) begin
            if (locked_i) nxt = ST_STAB;
            else if (m_waited + 1 == LOCK_TMO) nxt = ST_REALIGN;
            else m_waited++;
        end else if (m_mode == ST_REALIGN) begin
            if (m_pulse + 1 == RL_LEN) nxt = ST_WAIT;
            else m_pulse++;
        end else if (m_mode == ST_STAB) begin
            if (!locked_i) nxt = ST_WAIT;
            else if (bad == 1 || de == 1) m_run = 0;
            else if (good == 1) begin
                m_run++;
                if (m_run == STABLE) nxt = ST_UP;
            end
        end else if (m_mode == ST_UP || m_mode == ST_HIBER) begin
            if (!locked_i) nxt = ST_REALIGN;
            else if (m_errs + bad >= THRESH) begin
                if (m_mode == ST_UP) nxt = ST_HIBER;
                else begin
                    m_bad_wins++;
                    m_seen = 0; m_errs = 0;
                    if (m_bad_wins == HIB_LIM) nxt = ST_REALIGN;
                end
            end else if (head_valid_i) begin
                m_seen++;
                m_errs += bad;
                if (m_seen == WIN) begin
                    m_seen = 0; m_errs = 0;
                    if (m_mode == ST_HIBER) nxt = ST_UP;
                end
            end
        end
        if (clr_stats_i) begin
            m_err = 0; m_drop = 0;
        end else begin
            m_err = (m_err + bad + de > 65535) ? 65535 : m_err + bad + de;
            if (m_mode == ST_UP && nxt != ST_UP && m_drop < 65535) m_drop++;
        end
        if (nxt != m_mode) begin
            m_waited = 0; m_pulse = 0; m_run = 0; m_seen = 0; m_errs = 0; m_bad_wins = 0;
            m_mode = nxt;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        check("state", 32'(state_o), 32'(m_mode));
        check("realign", 32'(realign_o), 32'(m_mode == ST_REALIGN));
        check("dp_rst", 32'(dp_rst_o), 32'(m_mode == ST_RESET || m_mode == ST_WAIT || m_mode == ST_REALIGN));
        check("link_up", 32'(link_up_o), 32'(m_mode == ST_UP));
        check("hi_ber", 32'(hi_ber_o), 32'(m_mode == ST_HIBER));
`ifdef RX_LINK_STATS_EN
        check("err_cnt", 32'(err_cnt_o), 32'(m_err));
        check("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
`else
        check("err_cnt", 32'(err_cnt_o), 32'd0);
        check("drop_cnt", 32'(drop_cnt_o), 32'd0);
`endif
    endtask

    task automatic hdr(input logic hv, input logic [1:0] h, input int n);
        head_valid_i = hv;
        head_i       = h;
        repeat (n) tick();
    endtask

    task automatic bring_up();
        rst_i = 1'b1; locked_i = 1'b0; decode_error_i = 1'b0; clr_stats_i = 1'b0;
        hdr(1'b0, 2'b01, 2);
        rst_i = 1'b0; locked_i = 1'b1;
        head_valid_i = 1'b1; head_i = 2'b10;
        for (int i = 0; i < 200 && !link_up_o; i++) tick();
        check("bring_up", 32'(link_up_o), 32'd1);
    endtask

    initial begin
        int rise [2];
        int nrise, width, wide_ok, rst_seen_low, bad_pm, low_left;

        rst_i = 1'b1; head_i = 2'b00; head_valid_i = 1'b0; locked_i = 1'b0;
        decode_error_i = 1'b0; clr_stats_i = 1'b0;
        repeat (3) tick();
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_dp_rst", 32'(dp_rst_o), 32'd1);

        // Lock after 10 cycles, then 64 good headers.
        rst_i = 1'b0;
        repeat (10) tick();
        locked_i = 1'b1;
        tick();
        check("dp_rst_after_lock", 32'(dp_rst_o), 32'd0);
        hdr(1'b1, 2'b01, STABLE - 1);
        check("not_up_at_63", 32'(link_up_o), 32'd0);
        hdr(1'b1, 2'b01, 1);
        check("up_at_64", 32'(link_up_o), 32'd1);
        check("state_up", 32'(state_o), 32'd4);

        // Lock never arrives: periodic realign pulses, datapath held in reset.
        rst_i = 1'b1; locked_i = 1'b0;
        hdr(1'b0, 2'b00, 2);
        rst_i = 1'b0;
        nrise = 0; width = 0; wide_ok = 1; rst_seen_low = 0;
        for (int c = 1; c <= int'(LOCK_TMO + RL_LEN) * 2 + 10; c++) begin
            logic prev;
            prev = realign_o;
            tick();
            if (!dp_rst_o) rst_seen_low = 1;
            if (realign_o) width++;
            if (realign_o && !prev && nrise < 2) begin
                rise[nrise] = c;
                nrise++;
            end
            if (!realign_o && prev) begin
                if (width != int'(RL_LEN)) wide_ok = 0;
                width = 0;
            end
        end
        check("realign_rises", 32'(nrise), 32'd2);
        check("realign_first", 32'(rise[0]), 32'(LOCK_TMO + 1));
        check("realign_period", 32'(rise[1] - rise[0]), 32'(LOCK_TMO + RL_LEN));
        check("realign_width", 32'(wide_ok), 32'd1);
        check("dp_rst_held", 32'(rst_seen_low), 32'd0);

        // 16 bad headers in LINK_UP, then 8 threshold windows in HI_BER.
        bring_up();
        hdr(1'b1, 2'b11, THRESH);
        check("hiber_entry", 32'(hi_ber_o), 32'd1);
        check("hiber_linkdown", 32'(link_up_o), 32'd0);
`ifdef RX_LINK_STATS_EN
        check("drop_one", 32'(drop_cnt_o), 32'd1);
        check("err_sixteen", 32'(err_cnt_o), 32'd16);
`endif
        hdr(1'b1, 2'b00, THRESH * HIB_LIM - 1);
        check("hiber_hold", 32'(hi_ber_o), 32'd1);
        hdr(1'b1, 2'b11, 1);
        check("hiber_limit_realign", 32'(realign_o), 32'd1);

        // 15 bad per window does not trip; 16th on the final valid cycle does.
        bring_up();
        hdr(1'b1, 2'b11, THRESH - 1);
        hdr(1'b1, 2'b01, WIN - THRESH + 1);
        hdr(1'b1, 2'b00, THRESH - 1);
        check("fifteen_ok", 32'(link_up_o), 32'd1);
        hdr(1'b1, 2'b10, WIN - THRESH);
        hdr(1'b0, 2'b11, 5);
        hdr(1'b1, 2'b11, 1);
        check("last_cycle_hiber", 32'(hi_ber_o), 32'd1);
        hdr(1'b1, 2'b01, WIN);
        check("clean_window_up", 32'(link_up_o), 32'd1);

        // Lock loss beats hi-BER while bad headers stream.
        hdr(1'b1, 2'b11, 10);
        locked_i = 1'b0;
        hdr(1'b1, 2'b11, 1);
        check("lockloss_realign", 32'(realign_o), 32'd1);
        check("lockloss_no_hiber", 32'(hi_ber_o), 32'd0);
        hdr(1'b1, 2'b11, 2);
        rst_i = 1'b1;
        tick();
        check("rst_kills_pulse", 32'(realign_o), 32'd0);
        rst_i = 1'b0;

        // Biased random traffic.
        for (int ph = 0; ph < 20; ph++) begin
            bad_pm = (ph % 7 == 0) ? 0 : (ph % 7 == 1) ? 5 : (ph % 7 == 2) ? 12 : (ph % 7 == 3) ? 16 :
                     (ph % 7 == 4) ? 25 : (ph % 7 == 5) ? 60 : 300;
            locked_i = 1'b1; low_left = 0;
            for (int c = 0; c < 2000; c++) begin
                head_valid_i   = ($urandom_range(0, 99) < 90);
                head_i         = ($urandom_range(0, 999) < bad_pm) ? (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00)
                                                                   : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
                decode_error_i = ($urandom_range(0, 999) < 2);
                clr_stats_i    = ($urandom_range(0, 999) == 0);
                rst_i          = ($urandom_range(0, 19999) == 0);
                if (low_left > 0) begin
                    low_left--;
                    locked_i = (low_left == 0);
                end else if ($urandom_range(0, 3999) == 0) begin
                    locked_i = 1'b0;
                    low_left = $urandom_range(1, 5000);
                end
                tick();
            end
        end
        rst_i = 1'b0; clr_stats_i = 1'b0; decode_error_i = 1'b0; locked_i = 1'b1;

`ifdef RX_LINK_STATS_EN
        // Drive error counter into saturation, then clear it while it would still increment.
        clr_stats_i = 1'b1;
        tick();
        clr_stats_i = 1'b0; decode_error_i = 1'b1;
        hdr(1'b1, 2'b00, 32770);
        check("err_saturated", 32'(err_cnt_o), 32'h0000FFFF);
        clr_stats_i = 1'b1;
        tick();
        check("clr_wins", 32'(err_cnt_o), 32'd0);
        clr_stats_i = 1'b0; decode_error_i = 1'b0;
`else
        decode_error_i = 1'b1;
        hdr(1'b1, 2'b11, 100);
        check("stats_absent", 32'(err_cnt_o), 32'd0);
        decode_error_i = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
